lockstep_compare_monitor: RTL and testbench

- Parametrised lockstep checker for the dual-instance equivalence harness.
- Compares NCH lanes from implementation A against implementation B, each lane WIDTH bits wide.
- Each side has its own alignment delay line. Comparison is suppressed for a warm-up window after arm.
- Reports per-lane mismatch, a sticky fail flag, a saturating mismatch count and first-failure capture. Replaces the bare per-cycle equality assertion in top-level wrappers.

---
 rtl/lockstep_pkg.sv | 36 +++
 rtl/lockstep_compare_monitor_align.sv | 33 +++
 rtl/lockstep_compare_monitor.sv | 181 ++++++++++++++++++
 tb/tb_lockstep_compare_monitor.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
// Shared types and helpers for the lockstep compare monitor.
// Holds the checker FSM encoding plus counter and lane-select helpers.
package lockstep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_HALT   = 2'd3
  } state_e;

  localparam int MAX_W = 32;

  // Increment that sticks at the all-ones value of a w-bit counter.
  function automatic logic [MAX_W-1:0] sat_inc(
    input logic [MAX_W-1:0] v,
    input int unsigned      w
  );
    logic [MAX_W-1:0] top;
    top = (w >= MAX_W) ? '1
        : ((MAX_W'(1) << w) - MAX_W'(1));
    return (v >= top) ? v : v + MAX_W'(1);
  endfunction

  function automatic int unsigned lowest_set(
    input logic [MAX_W-1:0] v
  );
    int unsigned idx;
    idx = 0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (v[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lockstep_compare_monitor_align.sv
// Enable-gated alignment delay line; a depth of zero is a plain wire.
// The delay line is only cleared by reset, never by the checker clear.
module align_delay #(
  parameter int WIDTH_TOTAL = 16,
  parameter int DEPTH       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [WIDTH_TOTAL-1:0] d_i,
  output logic [WIDTH_TOTAL-1:0] d_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rst, en_i};
    assign d_o = d_i;
  end else begin : g_sr
    logic [WIDTH_TOTAL-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else if (en_i) begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign d_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/lockstep_compare_monitor.sv
// Lockstep checker: aligns two lane buses, compares after a warm-up
// window and keeps sticky fail, saturating counters and a first-fail capture.
module lockstep_compare_monitor
  import lockstep_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NCH          = 2,
  parameter int ALIGN_A      = 0,
  parameter int ALIGN_B      = 0,
  parameter int WARMUP       = 4,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 0,
  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic                 arm,
  input  logic                 clear,
  input  logic [NCH*WIDTH-1:0] data_a,
  input  logic [NCH*WIDTH-1:0] data_b,
  output logic [NCH-1:0]       mismatch_vec,
  output logic                 fail_sticky,
  output logic [CNT_W-1:0]     mismatch_count,
  output logic [CNT_W-1:0]     cycle_count,
  output logic [LW-1:0]        first_lane,
  output logic [CNT_W-1:0]     first_cycle,
  output logic [WIDTH-1:0]     first_a,
  output logic [WIDTH-1:0]     first_b,
  output logic [1:0]           state
);

  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  logic [NCH*WIDTH-1:0] a_al, b_al;
  logic [NCH-1:0]       diff;
  logic                 any_diff;
  logic [LW-1:0]        lane_idx;

  state_e               state_q, state_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;

  logic [NCH-1:0]       mvec_q, mvec_d;
  logic                 fail_q, fail_d;
  logic [CNT_W-1:0]     mcnt_q, mcnt_d;
  logic [CNT_W-1:0]     ccnt_q, ccnt_d;
  logic [LW-1:0]        flane_q, flane_d;
  logic [CNT_W-1:0]     fcyc_q, fcyc_d;
  logic [WIDTH-1:0]     fa_q, fa_d;
  logic [WIDTH-1:0]     fb_q, fb_d;

  align_delay #(.WIDTH_TOTAL(NCH*WIDTH), .DEPTH(ALIGN_A)) u_dly_a (
    .clk  (clk),
    .rst  (reset),
    .en_i (clk_enable),
    .d_i  (data_a),
    .d_o  (a_al)
  );

  align_delay #(.WIDTH_TOTAL(NCH*WIDTH), .DEPTH(ALIGN_B)) u_dly_b (
    .clk  (clk),
    .rst  (reset),
    .en_i (clk_enable),
    .d_i  (data_b),
    .d_o  (b_al)
  );

  always_comb begin
    diff = '0;
    for (int i = 0; i < NCH; i++) begin
      diff[i] = a_al[i*WIDTH +: WIDTH] != b_al[i*WIDTH +: WIDTH];
    end
  end

  assign any_diff = |diff;
  assign lane_idx = LW'(lowest_set(MAX_W'(diff)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else if (clk_enable) begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (clear) begin
      state_d = ST_IDLE;
      wcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d = ST_WARMUP;
            wcnt_d  = WCW'(WARMUP - 1);
          end
        end
        ST_WARMUP: begin
          if (wcnt_q == '0) state_d = ST_CHECK;
          else              wcnt_d  = wcnt_q - WCW'(1);
        end
        ST_CHECK: begin
          if (STOP_ON_FAIL != 0 && any_diff) state_d = ST_HALT;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Results advance only while checking; clear wins over any capture.
  always_comb begin
    mvec_d  = '0;
    fail_d  = fail_q;
    mcnt_d  = mcnt_q;
    ccnt_d  = ccnt_q;
    flane_d = flane_q;
    fcyc_d  = fcyc_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    if (clear) begin
      fail_d  = 1'b0;
      mcnt_d  = '0;
      ccnt_d  = '0;
      flane_d = '0;
      fcyc_d  = '0;
      fa_d    = '0;
      fb_d    = '0;
    end else if (state_q == ST_CHECK) begin
      mvec_d = diff;
      ccnt_d = CNT_W'(sat_inc(MAX_W'(ccnt_q), CNT_W));
      if (any_diff) begin
        mcnt_d = CNT_W'(sat_inc(MAX_W'(mcnt_q), CNT_W));
        if (!fail_q) begin
          fail_d  = 1'b1;
          flane_d = lane_idx;
          fcyc_d  = ccnt_q;
          fa_d    = a_al[lane_idx*WIDTH +: WIDTH];
          fb_d    = b_al[lane_idx*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mvec_q  <= '0;
      fail_q  <= 1'b0;
      mcnt_q  <= '0;
      ccnt_q  <= '0;
      flane_q <= '0;
      fcyc_q  <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else if (clk_enable) begin
      mvec_q  <= mvec_d;
      fail_q  <= fail_d;
      mcnt_q  <= mcnt_d;
      ccnt_q  <= ccnt_d;
      flane_q <= flane_d;
      fcyc_q  <= fcyc_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign mismatch_vec   = mvec_q;
  assign fail_sticky    = fail_q;
  assign mismatch_count = mcnt_q;
  assign cycle_count    = ccnt_q;
  assign first_lane     = flane_q;
  assign first_cycle    = fcyc_q;
  assign first_a        = fa_q;
  assign first_b        = fb_q;
  assign state          = state_q;

endmodule

// File: tb/tb_lockstep_compare_monitor.sv
// Scoreboard bench: directed stimulus queues expected snapshots,
// a negedge monitor pops and compares them against the instances.
module tb_lockstep_compare_monitor;

  typedef struct packed {
    logic [1:0]  st;
    logic [1:0]  mv;
    logic        f;
    logic [15:0] mc;
    logic [15:0] cc;
    logic        fl;
    logic [15:0] fc;
    logic [7:0]  fa;
    logic [7:0]  fb;
  } snap_t;

  typedef struct {
    string name;
    int    id;
    int    at;
    snap_t s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        en0, arm0, clr0;
  logic [15:0] a0, b0;
  logic        ens, arms, clrs;
  logic [15:0] as_, bs;

  logic [1:0]  o0_mv, o0_st;
  logic        o0_f;
  logic [15:0] o0_mc, o0_cc, o0_fc;
  logic [0:0]  o0_fl;
  logic [7:0]  o0_fa, o0_fb;

  logic [1:0]  o1_mv, o1_st;
  logic        o1_f;
  logic [3:0]  o1_mc, o1_cc, o1_fc;
  logic [0:0]  o1_fl;
  logic [7:0]  o1_fa, o1_fb;

  logic [1:0]  o2_mv, o2_st;
  logic        o2_f;
  logic [3:0]  o2_mc, o2_cc, o2_fc;
  logic [0:0]  o2_fl;
  logic [7:0]  o2_fa, o2_fb;

  lockstep_compare_monitor u0 (
    .clk(clk), .reset(rst), .clk_enable(en0), .arm(arm0),
    .clear(clr0), .data_a(a0), .data_b(b0),
    .mismatch_vec(o0_mv), .fail_sticky(o0_f),
    .mismatch_count(o0_mc), .cycle_count(o0_cc),
    .first_lane(o0_fl), .first_cycle(o0_fc),
    .first_a(o0_fa), .first_b(o0_fb), .state(o0_st)
  );

  lockstep_compare_monitor #(
    .ALIGN_A(3), .ALIGN_B(0), .WARMUP(2),
    .CNT_W(4), .STOP_ON_FAIL(1)
  ) u1 (
    .clk(clk), .reset(rst), .clk_enable(ens), .arm(arms),
    .clear(clrs), .data_a(as_), .data_b(bs),
    .mismatch_vec(o1_mv), .fail_sticky(o1_f),
    .mismatch_count(o1_mc), .cycle_count(o1_cc),
    .first_lane(o1_fl), .first_cycle(o1_fc),
    .first_a(o1_fa), .first_b(o1_fb), .state(o1_st)
  );

  lockstep_compare_monitor #(
    .ALIGN_A(0), .ALIGN_B(0), .WARMUP(2),
    .CNT_W(4), .STOP_ON_FAIL(0)
  ) u2 (
    .clk(clk), .reset(rst), .clk_enable(ens), .arm(arms),
    .clear(clrs), .data_a(as_), .data_b(bs),
    .mismatch_vec(o2_mv), .fail_sticky(o2_f),
    .mismatch_count(o2_mc), .cycle_count(o2_cc),
    .first_lane(o2_fl), .first_cycle(o2_fc),
    .first_a(o2_fa), .first_b(o2_fb), .state(o2_st)
  );

  exp_t  sb[$];
  exp_t  cur;
  snap_t act;
  int    tests = 0;
  int    fails = 0;
  bit    finish_req = 1'b0;

  function automatic snap_t mk(
    input int st, input int mv, input int f, input int mc,
    input int cc, input int fl, input int fc,
    input int fa, input int fb
  );
    snap_t r;
    r.st = 2'(st);
    r.mv = 2'(mv);
    r.f  = 1'(f);
    r.mc = 16'(mc);
    r.cc = 16'(cc);
    r.fl = 1'(fl);
    r.fc = 16'(fc);
    r.fa = 8'(fa);
    r.fb = 8'(fb);
    return r;
  endfunction

  function automatic snap_t grab(input int id);
    snap_t r;
    r = '0;
    case (id)
      0: begin
        r.st = o0_st; r.mv = o0_mv; r.f = o0_f;
        r.mc = o0_mc; r.cc = o0_cc; r.fl = o0_fl;
        r.fc = o0_fc; r.fa = o0_fa; r.fb = o0_fb;
      end
      1: begin
        r.st = o1_st; r.mv = o1_mv; r.f = o1_f;
        r.mc = 16'(o1_mc); r.cc = 16'(o1_cc); r.fl = o1_fl;
        r.fc = 16'(o1_fc); r.fa = o1_fa; r.fb = o1_fb;
      end
      default: begin
        r.st = o2_st; r.mv = o2_mv; r.f = o2_f;
        r.mc = 16'(o2_mc); r.cc = 16'(o2_cc); r.fl = o2_fl;
        r.fc = 16'(o2_fc); r.fa = o2_fa; r.fb = o2_fb;
      end
    endcase
    return r;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf(
      "st=%0d mv=%b f=%b mc=%0d cc=%0d fl=%0d fc=%0d a=%h b=%h",
      s.st, s.mv, s.f, s.mc, s.cc, s.fl, s.fc, s.fa, s.fb);
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      act = grab(cur.id);
      tests++;
      if (cur.at != cyc) begin
        fails++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d",
                 cur.name, cyc, cur.at);
      end else if (act !== cur.s) begin
        fails++;
        $display("FAIL %s: got %s | want %s",
                 cur.name, fmt(act), fmt(cur.s));
      end
    end
    if (finish_req || cyc > 20000) begin
      if (!finish_req) begin
        fails++;
        $display("FAIL watchdog: cycle %0d, limit 20000", cyc);
      end
      while (sb.size() > 0) begin
        cur = sb.pop_front();
        tests++;
        fails++;
        $display("FAIL %s: never sampled, slot %0d, now %0d",
                 cur.name, cur.at, cyc);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int id, input snap_t s);
    exp_t e;
    e.name = nm;
    e.id   = id;
    e.at   = cyc;
    e.s    = s;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] f0(input int j);
    return {8'(j * 7 + 1), 8'(j * 3 + 2)};
  endfunction

  function automatic logic [15:0] sa(input int n);
    return {8'(n * 3 + 1), 8'(n)};
  endfunction

  snap_t z;

  initial begin
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    en0 = 1'b1; arm0 = 1'b0; clr0 = 1'b0; a0 = '0; b0 = '0;
    ens = 1'b0; arms = 1'b0; clrs = 1'b0; as_ = '0; bs = '0;
    tick();
    chk("reset_u0", 0, z);
    chk("reset_u1", 1, z);
    rst = 1'b0;

    for (int j = 0; j <= 104; j++) begin
      arm0 = (j == 0);
      a0 = f0(j);
      b0 = a0;
      tick();
      if (j == 3)
        chk("warmup", 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      if (j == 4)
        chk("check_entry", 0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
      if (j == 104)
        chk("run100", 0, mk(2, 0, 0, 0, 100, 0, 0, 0, 0));
    end

    clr0 = 1'b1;
    tick();
    chk("clear", 0, z);
    clr0 = 1'b0;
    tick();
    chk("idle_hold", 0, z);

    for (int j = 0; j <= 22; j++) begin
      arm0 = (j == 0);
      a0 = f0(j);
      b0 = a0;
      if (j == 15) begin
        a0[15:8] = 8'h3C;
        b0[15:8] = 8'h5A;
      end
      if (j == 22) begin
        clr0 = 1'b1;
        b0 = ~a0;
      end
      tick();
      if (j == 15)
        chk("lane1_hit", 0,
            mk(2, 2'b10, 1, 1, 11, 1, 10, 8'h3C, 8'h5A));
      if (j == 16)
        chk("after_hit", 0,
            mk(2, 0, 1, 1, 12, 1, 10, 8'h3C, 8'h5A));
      if (j == 20) begin
        en0 = 1'b0;
        for (int g = 0; g < 5; g++) begin
          a0 = f0(g + 50);
          b0 = ~a0;
          tick();
        end
        chk("gap_hold", 0,
            mk(2, 0, 1, 1, 16, 1, 10, 8'h3C, 8'h5A));
        en0 = 1'b1;
      end
      if (j == 21)
        chk("after_gap", 0,
            mk(2, 0, 1, 1, 17, 1, 10, 8'h3C, 8'h5A));
      if (j == 22)
        chk("clear_vs_fail", 0, z);
    end
    clr0 = 1'b0;

    for (int j = 0; j <= 40; j++) begin
      arm0 = (j == 0);
      a0 = f0(j);
      b0 = a0;
      if (j == 25) begin
        a0 = 16'h3311;
        b0 = 16'h4422;
      end
      if (j == 35) begin
        a0[7:0] = 8'h77;
        b0[7:0] = 8'h66;
      end
      tick();
      if (j == 25)
        chk("both_lanes", 0,
            mk(2, 2'b11, 1, 1, 21, 0, 20, 8'h11, 8'h22));
      if (j == 35)
        chk("lane0_again", 0,
            mk(2, 2'b01, 1, 2, 31, 0, 20, 8'h11, 8'h22));
      if (j == 39)
        chk("pre_reset", 0,
            mk(2, 0, 1, 2, 35, 0, 20, 8'h11, 8'h22));
    end
    #2;
    rst = 1'b1;
    chk("async_reset", 0, z);
    arm0 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_idle", 0, z);

    ens = 1'b1;
    for (int n = 0; n <= 24; n++) begin
      arms = (n == 0);
      as_ = sa(n);
      bs = (n < 3) ? 16'h0000 : sa(n - 3);
      if (n == 20) bs[15:8] = bs[15:8] ^ 8'hFF;
      tick();
      if (n == 2) begin
        chk("skew_entry_u1", 1, mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("skew_entry_u2", 2, mk(2, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      if (n == 3) begin
        chk("aligned_first", 1, mk(2, 0, 0, 0, 1, 0, 0, 0, 0));
        chk("unaligned_first", 2,
            mk(2, 2'b11, 1, 1, 1, 0, 0, 8'h03, 8'h00));
      end
      if (n == 19) begin
        chk("aligned_clean", 1, mk(2, 0, 0, 0, 15, 0, 0, 0, 0));
        chk("unaligned_sat", 2,
            mk(2, 2'b11, 1, 15, 15, 0, 0, 8'h03, 8'h00));
      end
      if (n == 20)
        chk("stop_halt", 1,
            mk(3, 2'b10, 1, 1, 15, 1, 15, 8'h34, 8'hCB));
      if (n == 24) begin
        chk("halt_frozen", 1,
            mk(3, 0, 1, 1, 15, 1, 15, 8'h34, 8'hCB));
        chk("sat_hold", 2,
            mk(2, 2'b11, 1, 15, 15, 0, 0, 8'h03, 8'h00));
      end
    end

    tick();
    finish_req = 1'b1;
  end

endmodule
